// File: rtl/aes_mix_columns_seq.sv
// Column-serial AES MixColumns: one 32-bit column per clock between two
// valid/ready handshakes; the last-round flag passes the state through untouched.
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// BUSY  | mixing one column per cycle, busy=1
// DONE  | result held on out_data, out_valid=1 until out_ready
module aes_mix_columns_seq #(
  parameter int         NCOLS    = 4,
  parameter logic [7:0] RED_POLY = 8'h1b
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] in_data,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int            CW       = $clog2(NCOLS);
  localparam logic [CW-1:0] LAST_COL = CW'(NCOLS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            col_cnt;
  // Ascending packed index puts column 0 in the most significant 32 bits.
  logic [0:NCOLS-1][31:0]   st_reg;
  logic [0:NCOLS-1][31:0]   out_reg;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RED_POLY : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? DONE : BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (col_cnt == LAST_COL) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Columns not yet rewritten keep the previous transaction's values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_reg  <= '0;
      out_reg <= '0;
      col_cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      if (in_last) begin
        out_reg <= in_data;
      end else begin
        st_reg  <= in_data;
        col_cnt <= '0;
      end
    end else if (state == BUSY) begin
      out_reg[col_cnt] <= mix_col(st_reg[col_cnt]);
      col_cnt          <= (col_cnt == LAST_COL) ? '0 : col_cnt + 1'b1;
    end
  end

  assign out_data = out_reg;

endmodule
